packet_fifo_controller: RTL
===========================

Name: packet_fifo_controller

Overview:
Synchronous FIFO controller with packet mode. Beats are written tentatively and become visible to the reader only when the packet's last beat is committed. A packet can be dropped explicitly, and a packet that overflows is dropped automatically. It drives an external dual-port memory of width WIDTH+1, where the extra bit stores the last-beat flag. It sits in front of packet-oriented consumers that must never see partial or corrupted packets.

Parameters:
WIDTH, 8, payload bits per beat
DEPTH, 16, number of beats stored (any value >= 2, power of two not required)
DEPTH_LOG2, CLOG2(DEPTH), address width

Ports:
clock  input  1  clock; the only clock
resetn  input  1  reset, asynchronous, active-low
flush  input  1  discard all stored content, committed and pending
write_enable  input  1  write one beat
write_data  input  WIDTH  beat payload
write_last  input  1  beat is end of packet; commits the packet
write_drop  input  1  discard the uncommitted packet
read_enable  input  1  pop one committed beat
read_data  output  WIDTH  head beat payload
read_last  output  1  head beat is end of packet
empty  output  1  no committed beat
full  output  1  no free entry (committed plus pending = DEPTH)
level  output  DEPTH_LOG2+1  committed beats
pending  output  DEPTH_LOG2+1  uncommitted beats
space  output  DEPTH_LOG2+1  free entries
packet_count  output  DEPTH_LOG2+1  committed packets not yet fully read
write_miss  output  1  registered pulse: write attempted while full
read_error  output  1  registered pulse: read attempted while empty
packet_dropped  output  1  registered pulse: a packet was discarded
memory_clock  output  1  equals clock
memory_write_enable  output  1  memory write strobe
memory_write_address  output  DEPTH_LOG2  memory write address
memory_write_data  output  WIDTH+1  {write_last, write_data}
memory_read_enable  output  1  memory read strobe
memory_read_address  output  DEPTH_LOG2  memory read address
memory_read_data  input  WIDTH+1  {last, payload}; asynchronous read

Behaviour:
- Pointers: write_ptr (tentative), commit_ptr and read_ptr, each DEPTH_LOG2+1 bits, with the address in the low bits and a lap bit on top. Addresses wrap from DEPTH-1 to 0 and toggle the lap bit; non-power-of-two depths use explicit lap handling.
- level = commit_ptr - read_ptr, pending = write_ptr - commit_ptr, space = DEPTH - level - pending; all are lap-aware.
- empty = (level == 0), full = (space == 0); both combinational.
- Reset: all pointers 0, poison 0, packet_count 0. Outputs: empty=1, full=0, level=0, pending=0, space=DEPTH; write_miss, read_error and packet_dropped all 0.
- do_write = write_enable & !full & !poison & !write_drop & !flush. It writes memory at write_ptr and increments write_ptr.
- Commit: when write_enable & write_last & !full & !poison & !write_drop & !flush, the beat is written and commit_ptr is set to the incremented write_ptr on the same edge. packet_count increments.
- Overflow: write_enable while full (and no flush or drop) raises write_miss next cycle and sets poison. While poison is set, further beats are ignored, and those attempted while full also pulse write_miss.
- Poisoned packet end: write_enable & write_last while poison is set writes nothing. write_ptr rewinds to commit_ptr, poison clears, and packet_dropped pulses next cycle.
- write_drop (with or without write_enable): the beat is not written, write_ptr rewinds to commit_ptr, poison clears, and packet_dropped pulses next cycle, but only if pending > 0 or poison was set. write_drop takes priority over write_last.
- Read: do_read = read_enable & !empty & !flush. read_data and read_last come combinationally from memory_read_data at read_ptr. read_ptr increments on the edge. If read_last=1, packet_count decrements.
- read_enable while empty (no flush) pulses read_error next cycle. Uncommitted beats are never readable.
- A same-cycle commit and read are both applied; level reflects both after the edge. packet_count may increment and decrement in the same cycle and then stays unchanged.
- flush: write_ptr and read_ptr are loaded with commit_ptr, packet_count clears, poison clears, and all writes and reads in that cycle are ignored. No write_miss, read_error or packet_dropped pulse is generated.
- A packet longer than DEPTH can never commit; it is always dropped at its last beat.
- memory_write_enable = do_write; memory_read_enable = do_read; memory_clock = clock.
- Reset asserted mid-packet immediately returns all state to the reset values.

Test Plan:
- DEPTH=16: write a 3-beat packet, last on beat 3 -> pending goes 1, 2, then 0; level=3, packet_count=1, empty=0 only after the third edge.
- Write 2 beats then assert write_drop -> packet_dropped pulses 1 cycle, pending=0, level unchanged, memory untouched afterwards.
- DEPTH=5 (non-power-of-two): commit 4 packets of 1 beat, read 4, repeat 3 times -> wrap is correct, each read_last=1, level returns to 0, empty=1.
- DEPTH=4: write 6 beats, last on beat 6 -> full after beat 4, write_miss on beats 5 and 6, packet_dropped after beat 6, space=4.
- Commit a 2-beat packet while reading the last beat of a previous packet in the same cycle -> packet_count unchanged at 1, level=2.
- 5 committed beats plus 2 pending, then flush -> level=0, pending=0, empty=1, packet_count=0, no pulses; read while empty -> read_error pulses.

Source files
------------

// File: rtl/packet_fifo_controller.sv
// Packet-mode FIFO controller driving an external dual-port memory.
// Beats land tentatively behind write_ptr and become readable only when the
// packet's last beat moves commit_ptr. Overflowed or dropped packets are
// rewound so a consumer never sees a partial packet.
module packet_fifo_controller #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  write_enable,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  write_last,
  input  logic                  write_drop,
  input  logic                  read_enable,
  output logic [WIDTH-1:0]      read_data,
  output logic                  read_last,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   pending,
  output logic [DEPTH_LOG2:0]   space,
  output logic [DEPTH_LOG2:0]   packet_count,
  output logic                  write_miss,
  output logic                  read_error,
  output logic                  packet_dropped,
  output logic                  memory_clock,
  output logic                  memory_write_enable,
  output logic [DEPTH_LOG2-1:0] memory_write_address,
  output logic [WIDTH:0]        memory_write_data,
  output logic                  memory_read_enable,
  output logic [DEPTH_LOG2-1:0] memory_read_address,
  input  logic [WIDTH:0]        memory_read_data
);

  localparam int AW = DEPTH_LOG2;
  localparam int PW = AW + 1;

  // Pointer advance: the address wraps at DEPTH-1 (not at 2^AW) and flips the lap bit.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) f_inc = {~p[AW], {AW{1'b0}}};
    else                             f_inc = p + PW'(1);
  endfunction

  // Lap-aware distance a - b; differing lap bits mean a is one lap ahead.
  function automatic logic [PW-1:0] f_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] d;
    d = {1'b0, a[AW-1:0]} - {1'b0, b[AW-1:0]};
    if (a[AW] != b[AW]) d = d + PW'(DEPTH);
    return d;
  endfunction

  logic [PW-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pkt_cnt;
  logic          r_poison, r_write_miss, r_read_error, r_pkt_dropped;

  logic [PW-1:0] w_level, w_pending, w_space, w_wr_inc, w_rd_inc;
  logic          w_full, w_empty, w_do_write, w_commit, w_overflow, w_bad_end;
  logic          w_drop, w_drop_pulse, w_rewind, w_do_read, w_rd_err, w_rd_last_pop;

  assign w_level   = f_diff(r_cm_ptr, r_rd_ptr);
  assign w_pending = f_diff(r_wr_ptr, r_cm_ptr);
  assign w_space   = PW'(DEPTH) - w_level - w_pending;
  assign w_full    = (w_space == '0);
  assign w_empty   = (w_level == '0);
  assign w_wr_inc  = f_inc(r_wr_ptr);
  assign w_rd_inc  = f_inc(r_rd_ptr);

  // Write side qualification; flush and drop mask everything else.
  assign w_do_write   = write_enable & ~w_full & ~r_poison & ~write_drop & ~flush;
  assign w_commit     = w_do_write & write_last;
  assign w_overflow   = write_enable & w_full & ~write_drop & ~flush;
  // A last beat that cannot be stored (poisoned, or arriving while full) ends a
  // packet that can never commit, so it is discarded on the spot.
  assign w_bad_end    = write_enable & write_last & (r_poison | w_full) & ~write_drop & ~flush;
  assign w_drop       = write_drop & ~flush;
  assign w_drop_pulse = w_drop & ((w_pending != '0) | r_poison);
  assign w_rewind     = w_drop | w_bad_end;

  // Read side; only committed beats are visible.
  assign w_do_read     = read_enable & ~w_empty & ~flush;
  assign w_rd_err      = read_enable & w_empty & ~flush;
  assign w_rd_last_pop = w_do_read & memory_read_data[WIDTH];

  // Pointer, poison and packet-count state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_cm_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pkt_cnt <= '0;
      r_poison  <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= r_cm_ptr;
      r_rd_ptr  <= r_cm_ptr;
      r_pkt_cnt <= '0;
      r_poison  <= 1'b0;
    end else begin
      if (w_rewind) begin
        r_wr_ptr <= r_cm_ptr;
        r_poison <= 1'b0;
      end else begin
        if (w_do_write) r_wr_ptr <= w_wr_inc;
        if (w_commit)   r_cm_ptr <= w_wr_inc;
        if (w_overflow) r_poison <= 1'b1;
      end
      if (w_do_read) r_rd_ptr <= w_rd_inc;
      case ({w_commit, w_rd_last_pop})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // One-cycle status pulses reporting the previous edge's events.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_write_miss  <= 1'b0;
      r_read_error  <= 1'b0;
      r_pkt_dropped <= 1'b0;
    end else begin
      r_write_miss  <= w_overflow;
      r_read_error  <= w_rd_err;
      r_pkt_dropped <= w_drop_pulse | w_bad_end;
    end
  end

  assign read_data            = memory_read_data[WIDTH-1:0];
  assign read_last            = memory_read_data[WIDTH];
  assign empty                = w_empty;
  assign full                 = w_full;
  assign level                = w_level;
  assign pending              = w_pending;
  assign space                = w_space;
  assign packet_count         = r_pkt_cnt;
  assign write_miss           = r_write_miss;
  assign read_error           = r_read_error;
  assign packet_dropped       = r_pkt_dropped;
  assign memory_clock         = clock;
  assign memory_write_enable  = w_do_write;
  assign memory_write_address = r_wr_ptr[AW-1:0];
  assign memory_write_data    = {write_last, write_data};
  assign memory_read_enable   = w_do_read;
  assign memory_read_address  = r_rd_ptr[AW-1:0];

endmodule
